// File: rtl/d_mem_ctrl_pkg.sv
// d_mem_ctrl_pkg: shared word/offset widths and FSM state encodings for the data-memory path
package d_mem_ctrl_pkg;
  localparam int WORD_W = 32;
  localparam int OFF_W = 2;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 32 word storage, synchronous write, combinational read, no reset
module dmem_array
  import d_mem_ctrl_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IW = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [IW-1:0]     idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [DEPTH];
  // store on the access edge only; contents survive reset
  always_ff @(posedge clock)
    if (we) mem[idx] <= wdata;
  assign rdata = mem[idx];
endmodule

// File: rtl/d_mem_ctrl.sv
// d_mem_ctrl: req/ack word load/store responder with wait states; MISALIGN_CHECK_EN enables misaligned-access err
module d_mem_ctrl
  import d_mem_ctrl_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  output logic              err
);
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS_INIT = WAIT_STATES > 0 ? 4'(WAIT_STATES - 1) : 4'd0;
  state_t state, state_n;
  logic [3:0] cnt;
  logic we_q, err_q, accept, access, mis, acc_we, unused_addr;
  logic [IW+OFF_W-1:0] addr_q, acc_addr;
  logic [WORD_W-1:0] wdata_q, acc_wdata, mem_rd;
  assign accept = state == S_IDLE && req;
  // with no wait states the access happens on the accept edge, straight from the inputs
  assign access = (accept && WAIT_STATES == 0) || (state == S_WAIT && cnt == 4'd0);
  assign acc_we = state == S_IDLE ? we : we_q;
  assign acc_addr = state == S_IDLE ? addr[IW+OFF_W-1:0] : addr_q;
  assign acc_wdata = state == S_IDLE ? wdata : wdata_q;
  assign unused_addr = ^{addr[31:IW+OFF_W], acc_addr[OFF_W-1:0]};
`ifdef MISALIGN_CHECK_EN
  assign mis = acc_addr[OFF_W-1:0] != '0;
`else
  assign mis = 1'b0;
`endif
  dmem_array #(.DEPTH(DEPTH_WORDS), .IW(IW)) u_array (
    .clock(clock),
    .we(access && acc_we && !mis),
    .idx(acc_addr[IW+OFF_W-1:OFF_W]),
    .wdata(acc_wdata),
    .rdata(mem_rd)
  );
  // next state: IDLE -> WAIT (or straight to RESP) -> RESP -> IDLE
  always_comb begin
    state_n = state;
    state_n = accept ? (WAIT_STATES == 0 ? S_RESP : S_WAIT) :
              (state == S_WAIT && cnt == 4'd0) ? S_RESP :
              state == S_RESP ? S_IDLE : state;
  end
  // state, wait counter, load data and error flag; reset aborts any transaction
  always_ff @(posedge clock)
    if (reset) begin
      state <= S_IDLE;
      cnt <= 4'd0;
      rdata <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= accept ? WS_INIT : (state == S_WAIT && cnt != 4'd0) ? cnt - 4'd1 : cnt;
      if (access && !acc_we && !mis) rdata <= mem_rd;
      if (access) err_q <= mis;
    end
  // request fields are captured once at accept and held while busy
  always_ff @(posedge clock)
    if (accept) begin
      we_q <= we;
      addr_q <= addr[IW+OFF_W-1:0];
      wdata_q <= wdata;
    end
  assign ack = state == S_RESP;
  assign busy = state != S_IDLE;
  assign err = ack && err_q;
endmodule

// File: tb/tb_d_mem_ctrl.sv
// tb_d_mem_ctrl: directed checks of d_mem_ctrl with WAIT_STATES=2 (dut a) and WAIT_STATES=0 (dut b)
module tb_d_mem_ctrl;
  logic clock = 1'b0;
  logic reset;
  logic req_a, we_a, ack_a, busy_a, err_a;
  logic req_b, we_b, ack_b, busy_b, err_b;
  logic [31:0] addr_a, wdata_a, rdata_a, addr_b, wdata_b, rdata_b;
  int vectors = 0;
  int miscompares = 0;
  always #5 clock = ~clock;
  d_mem_ctrl #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut_a (
    .clock(clock), .reset(reset), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
    .rdata(rdata_a), .ack(ack_a), .busy(busy_a), .err(err_a)
  );
  d_mem_ctrl #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut_b (
    .clock(clock), .reset(reset), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
    .rdata(rdata_b), .ack(ack_b), .busy(busy_b), .err(err_b)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // one transaction on dut a (sel=0) or b (sel=1); lat counts cycles from accept edge to the ack cycle
  task automatic xact(input bit sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                      output int lat, output logic [31:0] rd, output logic e);
    bit seen;
    @(negedge clock);
    if (sel) begin req_b = 1; we_b = w; addr_b = a; wdata_b = d; end
    else begin req_a = 1; we_a = w; addr_a = a; wdata_a = d; end
    @(posedge clock);
    #1;
    if (sel) begin req_b = 0; we_b = ~w; addr_b = ~a; wdata_b = ~d; end
    else begin req_a = 0; we_a = ~w; addr_a = ~a; wdata_a = ~d; end
    lat = 0; rd = 'x; e = 1'bx; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      lat++;
      if (i == 0) check("busy_after_accept", sel ? busy_b : busy_a, 1);
      if (sel ? ack_b : ack_a) begin
        seen = 1;
        rd = sel ? rdata_b : rdata_a;
        e = sel ? err_b : err_a;
      end
    end
    if (!seen) lat = -1;
    @(negedge clock);
    check("ack_single_pulse", sel ? ack_b : ack_a, 0);
    check("busy_clear", sel ? busy_b : busy_a, 0);
  endtask
  initial begin
    int lat;
    logic [31:0] rd;
    logic e;
    logic [5:0] pat;
    logic any_ack;
    reset = 1;
    req_a = 0; we_a = 0; addr_a = 0; wdata_a = 0;
    req_b = 0; we_b = 0; addr_b = 0; wdata_b = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_rdata_a", rdata_a, 0);
    check("rst_ack_a", ack_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_err_a", err_a, 0);
    check("rst_rdata_b", rdata_b, 0);
    check("rst_ack_b", ack_b, 0);
    check("rst_busy_b", busy_b, 0);
    check("rst_err_b", err_b, 0);
    reset = 0;
    xact(0, 1, 32'h10, 32'hDEADBEEF, lat, rd, e);
    check("ws2_store_lat", lat, 3);
    check("ws2_store_rdata_kept", rd, 0);
    xact(0, 0, 32'h10, 32'h0, lat, rd, e);
    check("ws2_load_lat", lat, 3);
    check("ws2_load_data", rd, 32'hDEADBEEF);
    check("ws2_load_err", e, 0);
    xact(1, 1, 32'h0, 32'h12345678, lat, rd, e);
    check("ws0_store_lat", lat, 1);
    xact(1, 0, 32'h0, 32'h0, lat, rd, e);
    check("ws0_load_lat", lat, 1);
    check("ws0_load_data", rd, 32'h12345678);
    @(negedge clock);
    req_b = 1; we_b = 0; addr_b = 32'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      pat[i] = ack_b;
    end
    req_b = 0;
    check("ws0_b2b_ack_pattern", 32'(pat), 32'b010101);
    repeat (2) @(negedge clock);
    xact(0, 1, 32'h400, 32'hA5A5A5A5, lat, rd, e);
    xact(0, 0, 32'h000, 32'h0, lat, rd, e);
    check("wrap_load", rd, 32'hA5A5A5A5);
    xact(0, 1, 32'h20, 32'h00000001, lat, rd, e);
    @(negedge clock);
    req_a = 1; we_a = 1; addr_a = 32'h20; wdata_a = 32'hFFFFFFFF;
    @(posedge clock);
    #1 req_a = 0;
    @(negedge clock);
    check("abort_busy_in_wait", busy_a, 1);
    reset = 1;
    @(posedge clock);
    #1 reset = 0;
    any_ack = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (i == 0) check("abort_busy_cleared", busy_a, 0);
      any_ack |= ack_a;
    end
    check("abort_no_ack", any_ack, 0);
    xact(0, 0, 32'h20, 32'h0, lat, rd, e);
    check("abort_old_data", rd, 32'h00000001);
    xact(0, 0, 32'h13, 32'h0, lat, rd, e);
    check("misalign_lat", lat, 3);
`ifdef MISALIGN_CHECK_EN
    check("misalign_rdata", rd, 32'h00000001);
    check("misalign_err", e, 1);
`else
    check("misalign_rdata", rd, 32'hDEADBEEF);
    check("misalign_err", e, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
